monitor_verdict_collector: RTL
==============================

Name: monitor_verdict_collector

Overview:
- Downstream of the generated monitor topEntity; consumes its per-stream output values and activity flags (output_N, output_N_aktv).
- Timestamps every cycle with at least one active output, buffers it as a record in a small FIFO, and serialises it as one valid/ready beat per active stream.
- Output feeds the host log/UART bridge, so bursty monitor verdicts are never lost silently.

Parameters:
NUM_OUT, 2, number of monitor output streams
DATA_W, 64, width of each signed output value
TS_W, 32, timestamp width in clock cycles
DEPTH, 8, FIFO depth in records (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable shared with the monitor
out_data  in  NUM_OUT*DATA_W  concatenated monitor outputs, stream 0 in LSBs
out_aktv  in  NUM_OUT  per-stream active flags, bit i = stream i
m_valid  out  1  beat valid
m_ready  in  1  sink ready
m_data  out  DATA_W  value of the emitted stream
m_idx  out  IDX_W  index of the emitted stream, IDX_W = max(1, clog2(NUM_OUT))
m_ts  out  TS_W  timestamp of the record
m_last  out  1  last active stream of the record
overflow  out  1  sticky: at least one record dropped
drop_cnt  out  16  dropped-record count, saturating

Behaviour:
- Reset, while rst=0, asynchronous:
  - ts counter, FIFO pointers and count cleared; FSM forced to IDLE.
  - m_valid=0, m_data=0, m_idx=0, m_ts=0, m_last=0, overflow=0, drop_cnt=0.
  - Any in-flight beat or record is discarded; the first beat after reset comes from a freshly captured record.
- Timestamp:
  - ts increments by 1 on each edge with en=1; holds when en=0.
  - Wraps 2^TS_W-1 -> 0 with no flag.
- Capture, on a rising edge with en=1 and out_aktv != 0:
  - Record = {ts, out_aktv, out_data}, where ts is the pre-increment value.
  - Written if the FIFO is not full, or if it is full and the head record pops on the same edge.
  - Otherwise the record is dropped: drop_cnt += 1 (saturates at 0xFFFF), overflow <= 1.
  - out_aktv = 0 or en = 0: nothing is written.
- Serialiser FSM:
  - IDLE: if the FIFO is non-empty, load the head, set sel = lowest set aktv bit, go to SEND.
  - SEND: m_valid=1; m_data = data[sel]; m_idx = sel; m_ts = head ts; m_last = 1 iff no higher aktv bit is set.
  - SEND, handshake (m_valid && m_ready) with m_last=0: sel = next higher set bit.
  - SEND, handshake with m_last=1: pop the head. If the FIFO still holds another record, load it and stay in SEND (back-to-back, no bubble); else go to IDLE.
- Stream rules:
  - All m_* outputs are registered.
  - While m_valid=1 and m_ready=0, m_data, m_idx, m_ts and m_last are held stable.
  - m_valid never deasserts without a handshake, except on reset.
- Latency: a record captured at edge t gives m_valid=1 after edge t+2, with an empty FIFO and the FSM in IDLE.
- Throughput: one beat per cycle with m_ready held high.
- en=0 does not stall the serialiser: buffered records keep draining.
- Arithmetic: ts and drop_cnt are unsigned; data is passed through bit-exact (signed values are not reinterpreted).

Decomposition:
- Package monitor_collect_pkg holds:
  - IDX_W, and the record struct {ts, aktv, data[NUM_OUT]}.
  - FSM state enum {IDLE, SEND}.
  - DROP_SAT = 16'hFFFF.
- Sub-module verdict_fifo: synchronous single-clock FIFO of records.
  - Ports: push, pop, full, empty, head; registered pointers plus a count.
  - Push is accepted when full only if pop is asserted on the same edge.

Test Plan:
- Single record: aktv=2'b11, data=(1, 2) at ts=500 -> two beats: (idx0, 1, ts500, last0) then (idx1, 2, ts500, last1); m_valid first high 2 cycles after capture.
- Sparse record: aktv=2'b10, data1=7 -> exactly one beat: idx1, data 7, last=1; stream 0 value is never emitted.
- Backpressure: m_ready=0 for 5 cycles mid-record -> beat fields stable throughout; after release, second beat follows on the next cycle.
- Overflow: m_ready=0, 10 consecutive active cycles, DEPTH=8 -> 8 records kept, drop_cnt=2, overflow=1; draining returns records in ts order with the first 8 timestamps.
- Full plus simultaneous pop: FIFO full and a last-beat handshake coincide with a new capture -> record accepted, drop_cnt unchanged.
- Reset mid-beat: rst low while m_valid=1 -> all outputs 0 immediately; after rst high, ts restarts at 0 and the next capture is emitted normally.

Source files
------------

// File: rtl/monitor_collect_pkg.sv
// monitor_collect_pkg
//   Shared types and constants for the monitor verdict collector.
//   - NUM_OUT / DATA_W / TS_W : stream count, value width, timestamp width
//   - REC_DEPTH               : default FIFO depth in records
//   - IDX_W                   : width of a stream index
//   - rec_t                   : one buffered record {ts, aktv, data[NUM_OUT]}
//   - state_e                 : serialiser states
//   - first_set_from/is_last  : active-stream scan helpers
package monitor_collect_pkg;

    localparam int NUM_OUT   = 2;
    localparam int DATA_W    = 64;
    localparam int TS_W      = 32;
    localparam int REC_DEPTH = 8;
    localparam int IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // data[0] sits in the LSBs, matching the concatenated monitor bus.
    typedef struct packed {
        logic [TS_W-1:0]                    ts;
        logic [NUM_OUT-1:0]                 aktv;
        logic [NUM_OUT-1:0][DATA_W-1:0]     data;
    } rec_t;

    // Lowest active stream index that is >= from (0 if none).
    function automatic logic [IDX_W-1:0] first_set_from(input logic [NUM_OUT-1:0] aktv,
                                                        input int from);
        logic [IDX_W-1:0] sel;
        sel = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--)
            if (aktv[i] && (i >= from)) sel = IDX_W'(i);
        return sel;
    endfunction

    // True when no active stream lies above sel.
    function automatic logic is_last(input logic [NUM_OUT-1:0] aktv, input int sel);
        logic last;
        last = 1'b1;
        for (int i = 0; i < NUM_OUT; i++)
            if (aktv[i] && (i > sel)) last = 1'b0;
        return last;
    endfunction

endpackage

// File: rtl/verdict_fifo.sv
// verdict_fifo
//   Single-clock record FIFO with registered pointers and occupancy count.
//   Ports:
//     clk, rst      clock, async active-low reset (clears pointers/count)
//     push, wr_rec  write request and record
//     pop           remove head record
//     full, empty   occupancy flags
//     count         records held
//     head          oldest record
//     head_nxt      record behind the head (valid when count >= 2); lets the
//                   serialiser move to the next record on the popping edge
module verdict_fifo
    import monitor_collect_pkg::*;
#(
    parameter int DEPTH = REC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rec_t                     wr_rec,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output rec_t                     head,
    output rec_t                     head_nxt
);

    localparam int PTR_W = $clog2(DEPTH);

    rec_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_cnt;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_rd_nxt;

    assign full     = (r_cnt == (PTR_W+1)'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign count    = r_cnt;
    assign w_pop_ok = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign w_rd_nxt  = r_rd + 1'b1;
    assign head      = r_mem[r_rd];
    assign head_nxt  = r_mem[w_rd_nxt];

    always_ff @(posedge clk)
        if (w_push_ok) r_mem[r_wr] <= wr_rec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= w_rd_nxt;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/monitor_verdict_collector.sv
// monitor_verdict_collector
//   Timestamps every enabled cycle with an active monitor output, buffers it
//   as a record and serialises each record as one valid/ready beat per active
//   stream (lowest index first).
//   Ports:
//     clk, rst            clock, async active-low reset
//     en                  global enable (advances ts, gates capture)
//     out_data, out_aktv  monitor values (stream 0 in LSBs) and active flags
//     m_valid/m_ready     output handshake
//     m_data/m_idx/m_ts   beat value, stream index, record timestamp
//     m_last              final active stream of the record
//     overflow, drop_cnt  sticky drop flag and saturating drop count
module monitor_verdict_collector
    import monitor_collect_pkg::*;
#(
    parameter int DEPTH = REC_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [IDX_W-1:0]          m_idx,
    output logic [TS_W-1:0]           m_ts,
    output logic                      m_last,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]  r_ts;
    state_e           r_state;
    logic [IDX_W-1:0] r_sel;

    logic             w_cap;
    rec_t             w_wr_rec;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    rec_t             w_head;
    rec_t             w_head_nxt;
    logic             w_hs;
    logic             w_pop;

    state_e           w_state_nxt;
    logic [IDX_W-1:0] w_sel_nxt;
    logic             w_load;
    rec_t             w_src;
    logic             w_valid_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [TS_W-1:0]  w_ts_nxt;
    logic             w_last_nxt;

    assign w_cap    = en && (out_aktv != '0);
    assign w_wr_rec = {r_ts, out_aktv, out_data};
    assign w_hs     = m_valid && m_ready;

    verdict_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_cap),
        .wr_rec   (w_wr_rec),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .head     (w_head),
        .head_nxt (w_head_nxt)
    );

    // The head stays in the FIFO until its last beat is accepted, so a
    // record under transmission still occupies a slot.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_load      = 1'b0;
        w_src       = w_head;
        w_pop       = 1'b0;
        w_valid_nxt = m_valid;
        w_data_nxt  = m_data;
        w_idx_nxt   = m_idx;
        w_ts_nxt    = m_ts;
        w_last_nxt  = m_last;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_sel_nxt   = first_set_from(w_head.aktv, 0);
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!m_valid) begin
                    // first beat after IDLE: index was chosen on the previous edge
                    w_load = 1'b1;
                end else if (w_hs && !m_last) begin
                    w_sel_nxt = first_set_from(w_head.aktv, int'(r_sel) + 1);
                    w_load    = 1'b1;
                end else if (w_hs) begin
                    w_pop = 1'b1;
                    if (w_count != CNT_W'(1)) begin
                        w_src     = w_head_nxt;
                        w_sel_nxt = first_set_from(w_head_nxt.aktv, 0);
                        w_load    = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_load) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_src.data[w_sel_nxt];
            w_idx_nxt   = w_sel_nxt;
            w_ts_nxt    = w_src.ts;
            w_last_nxt  = is_last(w_src.aktv, int'(w_sel_nxt));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_ts    <= '0;
            m_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            m_valid <= w_valid_nxt;
            m_data  <= w_data_nxt;
            m_idx   <= w_idx_nxt;
            m_ts    <= w_ts_nxt;
            m_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (en) r_ts <= r_ts + 1'b1;
            if (w_cap && w_full && !w_pop) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_SAT) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
